// File: rtl/fetch_controller_if.sv
// fetch_controller_if: AXI4-Lite AR/R read channels, decode-side handshake and redirect input of the fetch stage.
interface fetch_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              arvalid_o;
  logic [ADDR_W-1:0] araddr_o;
  logic              arready_i;
  logic              rvalid_i;
  logic [DATA_W-1:0] rdata_i;
  logic [1:0]        rresp_i;
  logic              rready_o;
  logic              valid_post_o;
  logic              ready_post_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              fault_o;
  logic [1:0]        state_o;
  modport master (
    input  redirect_i, redirect_pc_i, arready_i, rvalid_i, rdata_i, rresp_i, ready_post_i,
    output arvalid_o, araddr_o, rready_o, valid_post_o, inst_o, pc_o, fault_o, state_o
  );
  modport slave (
    output redirect_i, redirect_pc_i, arready_i, rvalid_i, rdata_i, rresp_i, ready_post_i,
    input  arvalid_o, araddr_o, rready_o, valid_post_o, inst_o, pc_o, fault_o, state_o
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC, issues one AXI4-Lite read at a time and holds each word for decode.
module fetch_controller #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  fetch_controller_if.master        bus
);
  typedef enum logic [1:0] {S_AR = 2'b00, S_R = 2'b01, S_OUT = 2'b10} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc, r_redir_pc;
  logic [DATA_W-1:0] r_inst;
  logic              r_kill, r_fault;
  logic              w_r_fire, w_keep, w_busy;
  assign w_r_fire = (r_state == S_R) && bus.rvalid_i;
  assign w_keep   = w_r_fire && !r_kill && !bus.redirect_i;
  assign w_busy   = (r_state == S_AR) || (r_state == S_R);
  always_ff @(posedge clock)
    if (reset) r_state <= S_AR;
    else r_state <= w_next;
  always_comb begin
    w_next = S_AR;
    w_next = (r_state == S_AR) ? (bus.arready_i ? S_R : S_AR)
           : (r_state == S_R)  ? (!bus.rvalid_i ? S_R : (w_keep ? S_OUT : S_AR))
           : (r_state == S_OUT) ? ((bus.redirect_i || bus.ready_post_i) ? S_AR : S_OUT)
           : S_AR;
    bus.arvalid_o    = !reset && (r_state == S_AR);
    bus.araddr_o     = {r_pc[ADDR_W-1:2], 2'b00};
    bus.rready_o     = !reset && (r_state == S_R);
    bus.valid_post_o = !reset && (r_state == S_OUT) && !bus.redirect_i;
    bus.inst_o       = r_inst;
    bus.pc_o         = r_pc;
    bus.fault_o      = r_fault;
    bus.state_o      = r_state;
  end
  // A redirect while a read is outstanding is parked until the response drains.
  always_ff @(posedge clock)
    if (reset) begin
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_redir_pc <= '0;
      r_inst     <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (w_r_fire && !w_keep) begin
        r_pc   <= bus.redirect_i ? bus.redirect_pc_i : r_redir_pc;
        r_kill <= 1'b0;
      end else if (w_busy && bus.redirect_i) begin
        r_kill     <= 1'b1;
        r_redir_pc <= bus.redirect_pc_i;
      end
      if (w_keep) begin
        r_inst  <= bus.rdata_i;
        r_fault <= |bus.rresp_i;
      end
      if (r_state == S_OUT && bus.redirect_i) r_pc <= bus.redirect_pc_i;
      else if (r_state == S_OUT && bus.ready_post_i) r_pc <= r_pc + ADDR_W'(4);
    end
endmodule
